ws2811_frame_sequencer: RTL
===========================

// Module: ws2811_frame_sequencer
// PURPOSE
//  Frame-level controller for the ws2811 strip driver. Fires a driver start at a fixed frame rate.
//  Serves every driver data_request from a double-banked pixel RAM and applies global brightness.
//  Swaps RAM banks only at frame boundaries.
//  Sits between the host-written pixel RAM (1-cycle read latency) and the ws2811 driver.
// PARAMETERS
//  NUM_PIXELS    512       pixels per frame; must match the driver instance
//  SYSTEM_CLOCK  50000000  clk frequency in Hz
//  FRAME_RATE    50        frames per second; FRAME_CYCLES = SYSTEM_CLOCK/FRAME_RATE
//  ADDR_W        (derived) log2(NUM_PIXELS) pixel index width
// PORTS
//  clk               in   1         system clock
//  reset             in   1         asynchronous, active-high reset
//  enable            in   1         1 = frames are scheduled; 0 = no new frame starts
//  brightness        in   8         global scale; sampled at each frame start
//  swap_req          in   1         pulse: flip the display bank at the next frame start
//  swap_ack          out  1         1-cycle pulse when the flip takes effect
//  active_bank       out  1         bank being displayed; host writes the other bank
//  mem_rd_en         out  1         pixel RAM read strobe
//  mem_rd_addr       out  ADDR_W+1  {active_bank, pixel index}
//  mem_rd_data       in   24        {R[23:16], G[15:8], B[7:0]}; valid 1 cycle after mem_rd_en
//  drv_start         out  1         driver start, 1-cycle pulse
//  drv_data_request  in   1         driver data_request
//  drv_sending       in   1         driver sending flag
//  drv_red/green/blue out 8 each    scaled pixel presented to the driver
//  frame_done        out  1         1-cycle pulse at the end of each frame
//  overrun           out  1         sticky; set when a frame tick arrives while not in IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, state=IDLE, frame timer=0, index=0, pending swap cleared.
//  Frame timer: free-running 0..FRAME_CYCLES-1. tick = (timer==FRAME_CYCLES-1).
//   The timer runs even when enable=0.
//  FSM (binary encoded):
//   IDLE:  on tick && enable -> apply the pending swap, which toggles active_bank and pulses swap_ack.
//          Then latch brightness, index<=0, mem_rd_en=1 for one cycle -> FETCH.
//   FETCH: the cycle after the read, capture scaled mem_rd_data into drv_* -> START.
//   START: drv_start=1 for exactly one cycle -> RUN.
//   RUN:   on drv_data_request: if index<NUM_PIXELS-1 -> index++ and issue a read the next cycle.
//          drv_* update 2 cycles after the request.
//          Otherwise no read; index saturates.
//          On drv_sending falling edge (1 then 0) -> DONE.
//   DONE:  frame_done=1 for one cycle -> IDLE.
//  Timing contract:
//   - drv_* hold stable for the whole cycle following drv_data_request (the driver samples then).
//   - The next update lands >=2 cycles later; driver requests are >=24 bit-times apart.
//  Scaling: out = (c * (brightness+1)) >> 8, 16-bit intermediate.
//   Boundary cases: brightness 255 gives identity; brightness 0 gives 0.
//  swap_req:
//   - swap_req in any state sets pending; it is cleared when applied at the next frame start.
//   - A second swap_req before then is absorbed (no double flip).
//   - swap_req and an applying tick in the same cycle: the flip happens and pending stays set.
//  Overrun: tick in any state other than IDLE sets overrun (sticky until reset). That frame is skipped.
//  enable dropped mid-frame: the current frame completes; no new frame starts.
//  reset mid-frame: immediate return to reset values. The driver is expected to share reset.
//  Read addresses never exceed NUM_PIXELS-1 within the active bank.
// STRUCTURE
//  ws2811_pkg:
//   - log2 function and FRAME_CYCLES/CYCLE_COUNT derivation
//   - FSM state encodings
//   - RGB field offsets in the 24-bit pixel word
//  Sub-module ws2811_scale: one 8-bit channel, registered multiply-shift; instantiated 3x.
//  Top level: frame timer, FSM, index/bank registers, swap/overrun flags.
// TESTING
//  Bench setup: NUM_PIXELS=4, SYSTEM_CLOCK=8000000, FRAME_RATE=1000.
//  The bench uses a real ws2811 instance and a behavioural RAM.
//  1 Single frame: RAM bank0 = 0x112233,0x445566,0x778899,0xAABBCC; brightness=255.
//    -> one drv_start; driver latches exactly those 4 words in order; frame_done once.
//  2 Brightness: pixel 0x80FF01, brightness=127 -> drv_red/green/blue = 0x40,0x7F,0x00.
//  3 Swap: swap_req mid-frame -> active_bank toggles at the next frame start only.
//    swap_ack pulses once; that frame reads addresses 4..7.
//  4 Overrun: FRAME_RATE such that FRAME_CYCLES < frame length -> overrun=1.
//    Every other tick starts a frame; no drv_start while RUN.
//  5 Enable: deassert enable during RUN -> the frame finishes; no further drv_start.
//    Reassert -> next tick starts a frame.
//  6 Async reset asserted mid-RUN (between clock edges) -> all outputs 0 immediately.
//    Clean restart at the next tick.

Source files
------------

// File: rtl/ws2811_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2811_pkg
// Description : Shared helpers and encodings for the ws2811 frame sequencer:
//               log2 / frame-period derivation, FSM state codes and the
//               RGB field offsets inside the 24-bit pixel word.
// Revision    : 1.0 - initial release
// ============================================================================
package ws2811_pkg;

    // Smallest n such that 2**n >= value (0 for value <= 1).
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Clock cycles in one frame period.
    function automatic int frame_cycles(input int system_clock, input int frame_rate);
        return system_clock / frame_rate;
    endfunction

    // Width of a counter that spans 0..cycles-1, never narrower than 1 bit.
    function automatic int cycle_count_width(input int cycles);
        return (cycles > 1) ? log2_ceil(cycles) : 1;
    endfunction

    // Frame FSM encodings (binary).
    localparam int                   c_state_w  = 3;
    localparam logic [c_state_w-1:0] c_st_idle  = 3'd0;
    localparam logic [c_state_w-1:0] c_st_fetch = 3'd1;
    localparam logic [c_state_w-1:0] c_st_start = 3'd2;
    localparam logic [c_state_w-1:0] c_st_run   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_done  = 3'd4;

    // Channel positions in the {R, G, B} pixel word.
    localparam int c_red_lsb   = 16;
    localparam int c_green_lsb = 8;
    localparam int c_blue_lsb  = 0;

endpackage
`default_nettype wire

// File: rtl/ws2811_scale.sv
`default_nettype none
// ============================================================================
// Module      : ws2811_scale
// Description : One 8-bit colour channel scaled by global brightness:
//               scaled = (channel * (brightness + 1)) >> 8, registered.
//               Brightness 255 is identity, brightness 0 yields 0.
// Ports       : clk, reset (async, active-high), load (capture strobe),
//               brightness[7:0], channel[7:0] -> scaled[7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module ws2811_scale (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] brightness,
    input  logic [7:0] channel,
    output logic [7:0] scaled
);

    logic [8:0]  w_factor;
    logic [15:0] w_product;
    logic [7:0]  w_scaled;
    logic [7:0]  r_scaled;

    // brightness + 1 needs 9 bits; 255 * 256 still fits in 16.
    assign w_factor  = {1'b0, brightness} + 9'd1;
    assign w_product = {8'd0, channel} * {7'd0, w_factor};
    assign w_scaled  = 8'(w_product >> 8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scaled <= 8'd0;
        end else if (load) begin
            r_scaled <= w_scaled;
        end
    end

    assign scaled = r_scaled;

endmodule
`default_nettype wire

// File: rtl/ws2811_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ws2811_frame_sequencer
// Description : Frame-level controller for a ws2811 strip driver. Starts the
//               driver once per frame period, serves each driver data request
//               from a double-banked pixel RAM (1-cycle read latency) with
//               global brightness applied, and flips banks only at frame start.
// Ports       : clk, reset (async, active-high), enable, brightness[7:0],
//               swap_req / swap_ack, active_bank,
//               mem_rd_en / mem_rd_addr[ADDR_W:0] / mem_rd_data[23:0],
//               drv_start / drv_data_request / drv_sending,
//               drv_red / drv_green / drv_blue[7:0], frame_done, overrun
// Revision    : 1.0 - initial release
// ============================================================================
module ws2811_frame_sequencer
    import ws2811_pkg::*;
#(
    parameter int NUM_PIXELS   = 512,
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int FRAME_RATE   = 50,
    parameter int ADDR_W       = log2_ceil(NUM_PIXELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        brightness,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              active_bank,
    output logic              mem_rd_en,
    output logic [ADDR_W:0]   mem_rd_addr,
    input  logic [23:0]       mem_rd_data,
    output logic              drv_start,
    input  logic              drv_data_request,
    input  logic              drv_sending,
    output logic [7:0]        drv_red,
    output logic [7:0]        drv_green,
    output logic [7:0]        drv_blue,
    output logic              frame_done,
    output logic              overrun
);

    localparam int                  c_frame_cycles = frame_cycles(SYSTEM_CLOCK, FRAME_RATE);
    localparam int                  c_timer_w      = cycle_count_width(c_frame_cycles);
    localparam logic [c_timer_w-1:0] c_timer_last  = c_timer_w'(c_frame_cycles - 1);
    localparam logic [ADDR_W-1:0]   c_index_last   = ADDR_W'(NUM_PIXELS - 1);

    logic [c_timer_w-1:0] r_timer;
    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;
    logic [ADDR_W-1:0]    r_index;
    logic                 r_bank;
    logic                 r_swap_pending;
    logic                 r_swap_ack;
    logic                 r_overrun;
    logic [7:0]           r_bright;
    logic                 r_sending_q;
    logic                 r_fetch;      // read the freshly advanced index this cycle
    logic                 r_rd_valid;   // RAM data is valid this cycle

    logic                 w_tick;
    logic                 w_frame_start;
    logic                 w_bank_next;
    logic                 w_advance;
    logic                 w_rd_en;
    logic [ADDR_W:0]      w_rd_addr;
    logic                 w_drv_start;
    logic                 w_frame_done;

    assign w_tick        = (r_timer == c_timer_last);
    assign w_frame_start = (r_state == c_st_idle) && w_tick && enable;
    // The first read of a frame already targets the bank about to be shown.
    assign w_bank_next   = r_bank ^ r_swap_pending;
    assign w_advance     = (r_state == c_st_run) && drv_data_request && (r_index != c_index_last);

    // Free-running frame timer, independent of enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_timer_w'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_tick && enable) w_next_state = c_st_fetch;
            c_st_fetch: w_next_state = c_st_start;
            c_st_start: w_next_state = c_st_run;
            c_st_run:   if (r_sending_q && !drv_sending) w_next_state = c_st_done;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // FSM outputs. Pixel 0 is read in the starting IDLE cycle so that it is
    // scaled during FETCH; later pixels are read the cycle after the index moves.
    always_comb begin
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        w_drv_start  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_tick && enable) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = {w_bank_next, {ADDR_W{1'b0}}};
                end
            end
            c_st_start: w_drv_start  = 1'b1;
            c_st_done:  w_frame_done = 1'b1;
            default: ;
        endcase
        if (r_fetch) begin
            w_rd_en   = 1'b1;
            w_rd_addr = {r_bank, r_index};
        end
    end

    // Index, bank, brightness and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index        <= '0;
            r_bank         <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_ack     <= 1'b0;
            r_overrun      <= 1'b0;
            r_bright       <= 8'd0;
            r_sending_q    <= 1'b0;
            r_fetch        <= 1'b0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_swap_ack  <= 1'b0;
            r_fetch     <= 1'b0;
            r_rd_valid  <= w_rd_en;
            r_sending_q <= drv_sending;

            if (w_tick && (r_state != c_st_idle)) begin
                r_overrun <= 1'b1;
            end

            if (w_frame_start) begin
                r_bank     <= w_bank_next;
                r_swap_ack <= r_swap_pending;
                r_bright   <= brightness;
                r_index    <= '0;
            end else if (w_advance) begin
                r_index <= r_index + ADDR_W'(1);
                r_fetch <= 1'b1;
            end

            // A request arriving with the applying tick survives for the next frame.
            if (swap_req) begin
                r_swap_pending <= 1'b1;
            end else if (w_frame_start) begin
                r_swap_pending <= 1'b0;
            end
        end
    end

    ws2811_scale u_scale_red (
        .clk        (clk),
        .reset      (reset),
        .load       (r_rd_valid),
        .brightness (r_bright),
        .channel    (mem_rd_data[c_red_lsb +: 8]),
        .scaled     (drv_red)
    );

    ws2811_scale u_scale_green (
        .clk        (clk),
        .reset      (reset),
        .load       (r_rd_valid),
        .brightness (r_bright),
        .channel    (mem_rd_data[c_green_lsb +: 8]),
        .scaled     (drv_green)
    );

    ws2811_scale u_scale_blue (
        .clk        (clk),
        .reset      (reset),
        .load       (r_rd_valid),
        .brightness (r_bright),
        .channel    (mem_rd_data[c_blue_lsb +: 8]),
        .scaled     (drv_blue)
    );

    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = w_rd_addr;
    assign drv_start   = w_drv_start;
    assign frame_done  = w_frame_done;
    assign swap_ack    = r_swap_ack;
    assign active_bank = r_bank;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
